// File: rtl/ss_mac_array.sv
// ss_mac_array
// Frame-based multiply-free accumulator for stochastic-symbol channels.
// A frame starts from IDLE on a start request. Each accepted beat adds
// either one selected channel's symbol (mode=0) or the sum of all channel
// symbols (mode=1) into an ACC_W-bit accumulator. After len accepted beats
// the result is strobed for one cycle in DONE, then the block returns to IDLE.
//
// Handshake: in_ready is high exactly while the FSM is in RUN; a beat
// transfers on a rising clk edge where in_valid && in_ready. in_valid
// low in RUN is a bubble and changes nothing.
//
// Ports
//   clk, rst         clock (rising edge); asynchronous active-low reset
//   start            frame-start request, sampled only in IDLE
//   len              number of beats in the frame (0 = empty frame)
//   mode             0 = selected channel, 1 = sum of all channels
//   sel              channel index used when mode=0
//   sym_in           packed symbols, channel k at [k*SYM_W +: SYM_W]
//   in_valid         sym_in carries a beat
//   in_ready         block accepts a beat (state RUN)
//   busy             frame in progress (RUN or DONE)
//   acc_out          accumulator value, held in IDLE
//   out_valid        one-cycle result strobe (state DONE)
//   ovf              sticky overflow flag for the current frame
//   dbg_state        current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Build option
//   SS_MAC_SAT_EN    defined: an overflowing add clamps to 2^ACC_W-1;
//                    undefined: an overflowing add wraps modulo 2^ACC_W.

module ss_mac_array #(
  parameter int N_CH  = 8,
  parameter int SYM_W = 3,
  parameter int ACC_W = 9,
  parameter int LEN_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic                    mode,
  input  logic [$clog2(N_CH)-1:0] sel,
  input  logic [N_CH*SYM_W-1:0]   sym_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    busy,
  output logic [ACC_W-1:0]        acc_out,
  output logic                    out_valid,
  output logic                    ovf,
  output logic [1:0]              dbg_state
);

  localparam int SEL_W = $clog2(N_CH);
  localparam int SUM_W = SYM_W + SEL_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             mode_q, mode_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             ovf_q, ovf_d;

  // Addend path: purely combinational so an accepted beat lands in the
  // accumulator on the same edge.
  logic [SUM_W-1:0] sum_all;
  logic [SYM_W-1:0] sym_sel;
  logic [SUM_W-1:0] addend;
  logic [ACC_W:0]   sum_w;
  logic             carry;
  logic [ACC_W-1:0] acc_next;

  always_comb begin
    sum_all = '0;
    for (int k = 0; k < N_CH; k++) begin
      sum_all = sum_all + SUM_W'(sym_in[k*SYM_W +: SYM_W]);
    end
  end

  assign sym_sel = sym_in[sel_q*SYM_W +: SYM_W];
  assign addend  = mode_q ? sum_all : SUM_W'(sym_sel);
  assign sum_w   = {1'b0, acc_q} + (ACC_W+1)'(addend);
  assign carry   = sum_w[ACC_W];

`ifdef SS_MAC_SAT_EN
  // Clamp on carry; once at full scale, every further non-zero add
  // carries again, so the value stays pinned for the rest of the frame.
  assign acc_next = carry ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
  assign acc_next = sum_w[ACC_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      sel_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      sel_q   <= sel_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    mode_d  = mode_q;
    sel_d   = sel_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (len != '0) begin
            len_d   = len;
            mode_d  = mode;
            sel_d   = sel;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (in_valid) begin
          acc_d = acc_next;
          ovf_d = ovf_q | carry;
          cnt_d = cnt_q + 1'b1;
          // len_q is never zero in RUN, so len_q-1 is the last beat index.
          if (cnt_q == len_q - 1'b1) begin
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == RUN);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ss_mac_array.sv
// Directed testbench for ss_mac_array with default parameters.
module tb_ss_mac_array;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        mode;
  logic [2:0]  sel;
  logic [23:0] sym_in;
  logic        in_valid;
  logic        in_ready;
  logic        busy;
  logic [8:0]  acc_out;
  logic        out_valid;
  logic        ovf;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];

  ss_mac_array dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .mode      (mode),
    .sel       (sel),
    .sym_in    (sym_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .busy      (busy),
    .acc_out   (acc_out),
    .out_valid (out_valid),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] fill(input logic [2:0] v);
    logic [23:0] r;
    for (int k = 0; k < 8; k++) r[k*3 +: 3] = v;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic start_frame(input logic [7:0] l, input logic m, input logic [2:0] s);
    start = 1'b1;
    len   = l;
    mode  = m;
    sel   = s;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input int beats, input logic [23:0] sym);
    int got   = 0;
    int guard = 0;
    sym_in = sym;
    while (got < beats && guard < 100) begin
      in_valid = 1'b1;
      if (in_ready) got++;
      step();
      guard++;
    end
    in_valid = 1'b0;
    check("beats_accepted", got, beats);
  endtask

  task automatic check_result(input string tag, input logic exp_ovf);
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_out_valid"}, out_valid, 1);
      check({tag, "_acc"}, acc_out, e);
      check({tag, "_ovf"}, ovf, exp_ovf);
    end
  endtask

  initial begin
    logic [23:0] s;
    int pulses;
    rst      = 1'b0;
    start    = 1'b0;
    len      = '0;
    mode     = 1'b0;
    sel      = '0;
    sym_in   = '0;
    in_valid = 1'b0;
    repeat (3) step();

    check("rst_acc", acc_out, 0);
    check("rst_ovf", ovf, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b1;
    step();

    // mode 0, ch2 = 5 for 4 beats; other channels busy with 7
    s = fill(3'd7);
    s[8:6] = 3'd5;
    exp_q.push_back(9'd20);
    start_frame(8'd4, 1'b0, 3'd2);
    check("t1_busy", busy, 1);
    check("t1_in_ready", in_ready, 1);
    feed(4, s);
    check_result("t1", 1'b0);
    step();
    check("t1_pulse_end", out_valid, 0);
    check("t1_idle_busy", busy, 0);
    check("t1_hold", acc_out, 20);

    // mode 1, all 7, with a 3-cycle bubble between beats
    exp_q.push_back(9'd112);
    start_frame(8'd2, 1'b1, 3'd0);
    feed(1, fill(3'd7));
    repeat (3) step();
    check("t2_gap_acc", acc_out, 56);
    check("t2_gap_out_valid", out_valid, 0);
    check("t2_gap_ready", in_ready, 1);
    feed(1, fill(3'd7));
    check_result("t2", 1'b0);
    step();

    // mode 1, all 7, 10 beats: 560 overflows 9 bits
`ifdef SS_MAC_SAT_EN
    exp_q.push_back(9'd511);
`else
    exp_q.push_back(9'd48);
`endif
    start_frame(8'd10, 1'b1, 3'd0);
    feed(10, fill(3'd7));
    check_result("t3", 1'b1);
    step();
    check("t3_ovf_sticky_idle", ovf, 1);

    // empty frame: DONE right after start, ovf cleared
    exp_q.push_back(9'd0);
    start_frame(8'd0, 1'b0, 3'd0);
    check("t4_busy", busy, 1);
    check_result("t4", 1'b0);
    step();
    check("t4_pulse_end", out_valid, 0);

    // start/len/mode/sel disturbed mid-frame must be ignored
    s = fill(3'd7);
    s[5:3] = 3'd2;
    exp_q.push_back(9'd6);
    start_frame(8'd3, 1'b0, 3'd1);
    feed(1, s);
    start_frame(8'd1, 1'b1, 3'd5);
    check("t5_still_run", in_ready, 1);
    check("t5_mid_acc", acc_out, 2);
    feed(2, s);
    check_result("t5", 1'b0);
    step();

    // reset mid-frame
    s = fill(3'd7);
    s[2:0] = 3'd3;
    start_frame(8'd4, 1'b0, 3'd0);
    feed(2, s);
    rst = 1'b0;
    #1;
    check("t6_rst_acc", acc_out, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ready", in_ready, 0);
    check("t6_rst_out_valid", out_valid, 0);
    step();
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid) pulses++;
    end
    check("t6_no_pulse", pulses, 0);
    check("t6_idle_state", dbg_state, 0);
    exp_q.push_back(9'd3);
    start_frame(8'd1, 1'b0, 3'd0);
    feed(1, s);
    check_result("t6", 1'b0);
    step();

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
